rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter RESET_PTR, default 2'd0, setting the request index holding highest priority after reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits, request lines, one per requester, level-sampled each cycle.
REQ-005 The block SHALL have port grant_valid, output, 1 bit, asserted while a grant is offered downstream.
REQ-006 The block SHALL have port grant_ready, input, 1 bit, downstream accept; a grant transfers on a cycle with grant_valid and grant_ready both high.
REQ-007 The block SHALL have port grant_idx, output, 2 bits, binary index of the granted requester, i.e. the 4-to-2 encoding of grant_onehot.
REQ-008 The block SHALL have port grant_onehot, output, 4 bits, one-hot form of the grant; all zero when grant_valid is low.
REQ-009 The block SHALL have port pending, output, 4 bits, the registered set of requests not yet served.

Function
REQ-010 The block SHALL capture requests stickily: at each edge, pending gets pending OR req, except for the bit cleared by an accepted grant (REQ-016).
REQ-011 The block SHALL implement a two-state FSM: IDLE (grant_valid low) and OFFER (grant_valid high), with grant_valid a registered output.
REQ-012 In IDLE, if (pending OR req) is non-zero, the block SHALL select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), register its index into grant_idx and enter OFFER at the next edge.
REQ-013 Latency SHALL be one cycle: req bit high at edge k with the FSM in IDLE gives grant_valid high immediately after edge k.
REQ-014 In IDLE with (pending OR req) zero, the block SHALL remain in IDLE, with grant_idx holding its last value and grant_onehot zero.
REQ-015 In OFFER with grant_ready low, grant_idx and grant_onehot SHALL remain stable and no re-arbitration SHALL occur, even if higher-priority requests arrive.
REQ-016 In OFFER with grant_ready high, at that edge the block SHALL:
- set pending[grant_idx] to req[grant_idx], so a same-cycle re-request wins over the clear;
- set ptr to grant_idx+1 mod 4, wrapping 3 to 0;
- return to IDLE.
REQ-017 After each accepted grant the block SHALL spend exactly one cycle in IDLE before the next grant_valid, giving a maximum throughput of one grant per two cycles.
REQ-018 grant_onehot SHALL equal 4'b0001 shifted left by grant_idx while in OFFER.
REQ-019 A request deasserted after capture SHALL remain in pending until it is granted; pending bits are cleared only by an accepted grant or by reset.
REQ-020 With all four requests permanently high, the block SHALL grant in rotating order starting from RESET_PTR, with no requester served twice before each other requester has been served once.

Reset
REQ-021 rst_n low SHALL immediately, regardless of clk, force: state IDLE, grant_valid 0, grant_onehot 4'b0000, grant_idx 2'b00, pending 4'b0000, ptr RESET_PTR.
REQ-022 Reset asserted during OFFER SHALL discard the offered grant and all pending requests, with no transfer counted for that cycle.
REQ-023 After rst_n rises, the first rising clk edge SHALL sample req normally, so grant_valid can assert one cycle after deassertion.

Verification
REQ-024 Single request: RESET_PTR=0, req=4'b0100 for one cycle, grant_ready=1 -> next cycle grant_valid=1, grant_idx=2, grant_onehot=4'b0100; following cycle grant_valid=0, pending=0.
REQ-025 Round robin: req=4'b1111 held, grant_ready=1 -> grant_idx sequence 0,1,2,3,0 on alternate cycles.
REQ-026 Backpressure: req=4'b0010, grant_ready=0 for 5 cycles, then req=4'b0001 -> grant_idx stays 1 and stable throughout; after ready=1 the next grant is idx 0.
REQ-027 Sticky and same-cycle re-request: req[3] pulsed during another grant -> served later; req[3] held high across its own accept -> pending[3] stays 1 and idx 3 is re-granted after the others are served.
REQ-028 Reset mid-offer: rst_n=0 while grant_valid=1 -> grant_valid=0 and pending=0 within the same cycle, without a clock edge; ptr back to RESET_PTR.
REQ-029 Encoder consistency: in every OFFER cycle of a random run, grant_onehot is one-hot and encodes to grant_idx.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//   Four-requester round-robin arbiter with a valid/ready grant handshake.
//   Requests are captured stickily into a pending set. From IDLE the arbiter
//   picks the first requester at or after the rotating priority pointer and
//   offers it downstream. The offer is held, without re-arbitration, until it
//   is accepted. After an accepted grant the pointer moves just past the
//   winner, and the FSM spends one cycle in IDLE.
//
// Parameters
//   RESET_PTR    : requester index holding highest priority after reset
//
// Ports
//   clk          : in  1  single clock, rising edge
//   rst_n        : in  1  asynchronous active-low reset
//   req          : in  4  request lines, level-sampled every cycle
//   grant_valid  : out 1  a grant is being offered
//   grant_ready  : in  1  downstream accept (transfer when valid & ready)
//   grant_idx    : out 2  binary index of the offered grant
//   grant_onehot : out 4  one-hot form of the grant, zero when not valid
//   pending      : out 4  registered set of requests not yet served
// -----------------------------------------------------------------------------
module rr_arbiter_4 #(
  parameter logic [1:0] RESET_PTR = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       grant_valid,
  input  logic       grant_ready,
  output logic [1:0] grant_idx,
  output logic [3:0] grant_onehot,
  output logic [3:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] onehot_q, onehot_d;
  logic [3:0] pend_q, pend_d;

  logic [3:0] req_all;
  logic [1:0] sel_idx;
  logic       sel_found;

  // A request arriving this cycle is visible to arbitration straight away,
  // which is what gives the one-cycle request-to-grant latency.
  assign req_all = pend_q | req;

  // Rotating priority search: ptr, ptr+1, ptr+2, ptr+3, wrapping mod 4.
  // NOTE: every variable written in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    sel_idx   = ptr_q;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sel_found && req_all[ptr_q + 2'(i)]) begin
        sel_idx   = ptr_q + 2'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    pend_d   = req_all;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          idx_d    = sel_idx;
          onehot_d = 4'b0001 << sel_idx;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        // The offer is frozen until accepted, even if higher-priority requests
        // arrive. On accept, a same-cycle re-request by the winner wins over
        // the clear.
        if (grant_ready) begin
          pend_d[idx_q] = req[idx_q];
          ptr_d         = idx_q + 2'd1;
          onehot_d      = 4'b0000;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= RESET_PTR;
      idx_q    <= 2'b00;
      onehot_q <= 4'b0000;
      pend_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      pend_q   <= pend_d;
    end
  end

  assign grant_valid  = (state_q == OFFER);
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign pending      = pend_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4
//   Self-checking bench for rr_arbiter_4 (RESET_PTR = 0). A behavioural model
//   tracks the offered requester, the pending set and the priority pointer as
//   plain integers. Every cycle the model is compared with the DUT. Directed
//   scenarios check the handshake corner cases against constants. A
//   randomized run with encoder checks follows.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4;

  localparam int RST_PTR = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       grant_valid;
  logic       grant_ready;
  logic [1:0] grant_idx;
  logic [3:0] grant_onehot;
  logic [3:0] pending;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  bit       m_offer;
  int       m_idx;
  int       m_ptr;
  bit [3:0] m_pend;

  rr_arbiter_4 #(.RESET_PTR(2'(RST_PTR))) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_offer = 1'b0;
    m_idx   = 0;
    m_ptr   = RST_PTR;
    m_pend  = 4'b0000;
  endtask

  // Advance the model by one rising edge, given the inputs seen at that edge.
  task automatic model_edge(input bit [3:0] r, input bit rdy);
    bit [3:0] all;
    all = m_pend | r;
    if (!m_offer) begin
      m_pend = all;
      for (int k = 0; k < 4; k++) begin
        if (!m_offer && all[(m_ptr + k) % 4]) begin
          m_idx   = (m_ptr + k) % 4;
          m_offer = 1'b1;
        end
      end
    end else if (rdy) begin
      m_pend        = all;
      m_pend[m_idx] = r[m_idx];
      m_ptr         = (m_idx + 1) % 4;
      m_offer       = 1'b0;
    end else begin
      m_pend = all;
    end
  endtask

  task automatic compare_all();
    check("grant_valid", 32'(grant_valid), 32'(m_offer));
    check("grant_idx", 32'(grant_idx), 32'(m_idx));
    check("grant_onehot", 32'(grant_onehot), m_offer ? (32'd1 << m_idx) : 32'd0);
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  // Called at a falling edge: drive inputs, take the rising edge, then compare
  // at the next falling edge.
  task automatic step(input logic [3:0] r, input logic rdy);
    req         = r;
    grant_ready = rdy;
    @(posedge clk);
    model_edge(r, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    grant_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int seq[$];

  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    grant_ready = 1'b0;
    model_reset();
    #3;
    // Reset state before any clock edge.
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_onehot", 32'(grant_onehot), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, first edge after reset release samples it.
    step(4'b0100, 1'b1);
    check("single_valid", 32'(grant_valid), 32'd1);
    check("single_idx", 32'(grant_idx), 32'd2);
    check("single_onehot", 32'(grant_onehot), 32'b0100);
    step(4'b0000, 1'b1);
    check("single_done_valid", 32'(grant_valid), 32'd0);
    check("single_done_pend", 32'(pending), 32'd0);

    // Round robin with all requests held.
    do_reset();
    seq.delete();
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b1);
      if (grant_valid) seq.push_back(int'(grant_idx));
    end
    check("rr_count", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(i % 4));

    // Backpressure: offer stays frozen while a lower-index request arrives.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b0);
      check("bp_idx", 32'(grant_idx), 32'd1);
      check("bp_valid", 32'(grant_valid), 32'd1);
    end
    step(4'b0001, 1'b0);
    check("bp_hold_idx", 32'(grant_idx), 32'd1);
    step(4'b0000, 1'b1);
    check("bp_accept_valid", 32'(grant_valid), 32'd0);
    step(4'b0000, 1'b1);
    check("bp_next_idx", 32'(grant_idx), 32'd0);
    check("bp_next_valid", 32'(grant_valid), 32'd1);

    // Sticky pulse of req[3] during another grant.
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b1);
    check("sticky_pend", 32'(pending), 32'b1000);
    step(4'b0000, 1'b1);
    check("sticky_idx", 32'(grant_idx), 32'd3);
    check("sticky_valid", 32'(grant_valid), 32'd1);

    // req[3] held across its own accept: re-granted after requester 1.
    do_reset();
    step(4'b1001, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    check("rereq_idx3", 32'(grant_idx), 32'd3);
    step(4'b1010, 1'b1);
    check("rereq_pend", 32'(pending), 32'b1010);
    step(4'b0000, 1'b1);
    check("rereq_idx1", 32'(grant_idx), 32'd1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("rereq_idx3b", 32'(grant_idx), 32'd3);
    check("rereq_valid", 32'(grant_valid), 32'd1);

    // Reset mid-offer, asserted away from any clock edge; pointer restored.
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    check("mid_pre_idx", 32'(grant_idx), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_valid", 32'(grant_valid), 32'd0);
    check("mid_pending", 32'(pending), 32'd0);
    check("mid_onehot", 32'(grant_onehot), 32'd0);
    check("mid_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    check("mid_ptr_idx", 32'(grant_idx), 32'(RST_PTR));

    // Randomized run against the model, with encoder consistency.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(r, 1'($urandom_range(0, 2) != 0));
      if (grant_valid) begin
        check("enc_onehot", 32'($onehot(grant_onehot)), 32'd1);
        check("enc_idx", 32'(grant_onehot), 32'd1 << grant_idx);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
